// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU blocks.
//   alu_op_t    - 3-bit opcode encoding understood by alu_core
//   arb_state_t - result-slot state of alu_arbiter
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_CAT = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
// Ports:
//   op   in  3     opcode (alu_op_t encoding)
//   a    in  W     operand A
//   b    in  W     operand B
//   data out 2W    result; operands zero-extended, arithmetic mod 2^(2W)
//   err  out 1     reserved opcode was used (data forced to 0)
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] data,
  output logic           err
);

  logic [2*W-1:0] w_a_ext;
  logic [2*W-1:0] w_b_ext;

  assign w_a_ext = {{W{1'b0}}, a};
  assign w_b_ext = {{W{1'b0}}, b};

  // Opcode decode; every result is truncated to 2W bits by the assignment width.
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (alu_op_t'(op))
      OP_ADD:  data = w_a_ext + w_b_ext;
      OP_SUB:  data = w_a_ext - w_b_ext;
      OP_AND:  data = w_a_ext & w_b_ext;
      OP_OR:   data = w_a_ext | w_b_ext;
      OP_XOR:  data = w_a_ext ^ w_b_ext;
      OP_CAT:  data = {a, b};
      OP_MUL:  data = w_a_ext * w_b_ext;
      OP_RSV: begin
        data = '0;
        err  = 1'b1;
      end
      default: begin
        data = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one alu_core between two
// requesters, with a single registered result slot.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/reqN_ready    request handshake for requester N (0/1)
//   reqN_op, reqN_a, reqN_b  opcode and W-bit operands
//   out_valid/out_ready      result handshake toward the consumer
//   out_data [2W]            registered result
//   out_id                   requester that produced out_data
//   out_err                  reserved opcode was used
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [2:0]     req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [2:0]     req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_data,
  output logic           out_id,
  output logic           out_err
);

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic           r_last_grant;
  logic [2*W-1:0] r_out_data;
  logic           r_out_id;
  logic           r_out_err;

  logic           w_free;
  logic           w_grant0;
  logic           w_grant1;
  logic           w_acc0;
  logic           w_acc1;
  logic           w_acc;
  logic [2:0]     w_sel_op;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic [2*W-1:0] w_alu_data;
  logic           w_alu_err;

  // Grant, ready and next-state logic. The slot is free when empty or when
  // the held result leaves on this edge; on contention the requester not
  // served last wins. Readies are masked during reset so nothing completes.
  always_comb begin
    w_free      = 1'b0;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_acc0      = 1'b0;
    w_acc1      = 1'b0;
    w_acc       = 1'b0;
    w_state_nxt = r_state;

    if (r_state == ST_IDLE) begin
      w_free = 1'b1;
    end else begin
      w_free = out_ready;
    end

    if (req0_valid && req1_valid) begin
      w_grant0 = r_last_grant;
      w_grant1 = ~r_last_grant;
    end else begin
      w_grant0 = req0_valid;
      w_grant1 = req1_valid;
    end

    w_acc0 = ~rst & w_free & w_grant0;
    w_acc1 = ~rst & w_free & w_grant1;
    w_acc  = w_acc0 | w_acc1;

    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_acc) begin
          w_state_nxt = ST_BUSY;
        end else if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand mux feeding the shared core; only meaningful on an accept edge.
  always_comb begin
    if (w_grant1) begin
      w_sel_op = req1_op;
      w_sel_a  = req1_a;
      w_sel_b  = req1_b;
    end else begin
      w_sel_op = req0_op;
      w_sel_a  = req0_a;
      w_sel_b  = req0_b;
    end
  end

  alu_core #(.W(W)) u_alu_core (
    .op   (w_sel_op),
    .a    (w_sel_a),
    .b    (w_sel_b),
    .data (w_alu_data),
    .err  (w_alu_err)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result slot and round-robin pointer; loaded only on an accept edge so
  // the held result stays put while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data   <= '0;
      r_out_id     <= 1'b0;
      r_out_err    <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_acc) begin
      r_out_data   <= w_alu_data;
      r_out_id     <= w_acc1;
      r_out_err    <= w_alu_err;
      r_last_grant <= w_acc1;
    end
  end

  assign req0_ready = w_acc0;
  assign req1_ready = w_acc1;
  assign out_valid  = (r_state == ST_BUSY);
  assign out_data   = r_out_data;
  assign out_id     = r_out_id;
  assign out_err    = r_out_err;

endmodule
